// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and defaults for the branch predictor resolution side
package bp_pkg;

  localparam int BP_PC_W     = 10;
  localparam int BP_RQ_DEPTH = 8;

  typedef struct packed {
    logic [BP_PC_W-1:0] pc;
    logic               taken;
  } bp_entry_t;

  typedef enum logic {
    ACTIVE = 1'b0,
    FLUSH  = 1'b1
  } rq_state_e;

endpackage

// File: rtl/bp_sat_count.sv
// rtl/bp_sat_count.sv - saturating up-counter that sticks at all-ones
module bp_sat_count #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - in-order queue of issued predictions; resolves, trains and flushes on mispredict
module branch_resolve_queue
  import bp_pkg::*;
#(
  parameter int DEPTH  = BP_RQ_DEPTH,
  parameter int PC_W   = BP_PC_W,
  parameter int STAT_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     pred_valid,
  input  logic [PC_W-1:0]          pred_pc,
  input  logic                     pred_taken,
  output logic                     pred_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     upd_valid,
  output logic [PC_W-1:0]          upd_pc,
  output logic                     upd_taken,
  output logic                     mispredict,
  output logic [PC_W-1:0]          mispredict_pc,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [STAT_W-1:0]        resolved_cnt,
  output logic [STAT_W-1:0]        mispred_cnt,
  output logic                     underflow_err
);

  localparam int AW = $clog2(DEPTH);

  rq_state_e r_state, w_state_nxt;

  logic [PC_W-1:0] r_mem_pc    [DEPTH];
  logic            r_mem_taken [DEPTH];

  logic [AW:0]     r_wptr, r_rptr, w_wptr_nxt, w_rptr_nxt;
  logic [AW:0]     r_occ;
  logic            r_upd_valid, r_upd_taken, r_mispredict, r_underflow;
  logic [PC_W-1:0] r_upd_pc, r_mispredict_pc;

  logic            w_full, w_empty, w_active;
  logic            w_resolve, w_mispred, w_correct, w_push, w_underflow;
  logic [PC_W-1:0] w_head_pc;
  logic            w_head_taken;

  assign w_full       = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_empty      = (r_wptr == r_rptr);
  assign w_active     = (r_state == ACTIVE);
  assign w_head_pc    = r_mem_pc[r_rptr[AW-1:0]];
  assign w_head_taken = r_mem_taken[r_rptr[AW-1:0]];

  // Resolutions are only honoured in ACTIVE; the FLUSH cycle swallows them silently.
  assign w_resolve   = res_valid && !w_empty && w_active;
  assign w_mispred   = w_resolve && (w_head_taken != res_taken);
  assign w_correct   = w_resolve && !w_mispred;
  assign w_underflow = res_valid && w_empty && w_active;

  assign pred_ready = w_active && !w_mispred && (!w_full || w_correct);
  assign w_push     = pred_valid && pred_ready;

  assign w_wptr_nxt = w_push ? (r_wptr + (AW+1)'(1)) : r_wptr;
  assign w_rptr_nxt = w_mispred ? r_wptr :
                      w_correct ? (r_rptr + (AW+1)'(1)) : r_rptr;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_pc[r_wptr[AW-1:0]]    <= pred_pc;
      r_mem_taken[r_wptr[AW-1:0]] <= pred_taken;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ACTIVE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACTIVE:  if (w_mispred) w_state_nxt = FLUSH;
      FLUSH:   w_state_nxt = ACTIVE;
      default: w_state_nxt = ACTIVE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr          <= '0;
      r_rptr          <= '0;
      r_occ           <= '0;
      r_upd_valid     <= 1'b0;
      r_upd_pc        <= '0;
      r_upd_taken     <= 1'b0;
      r_mispredict    <= 1'b0;
      r_mispredict_pc <= '0;
      r_underflow     <= 1'b0;
    end else begin
      r_wptr          <= w_wptr_nxt;
      r_rptr          <= w_rptr_nxt;
      r_occ           <= w_wptr_nxt - w_rptr_nxt;
      r_upd_valid     <= w_resolve;
      r_upd_pc        <= w_resolve ? w_head_pc : '0;
      r_upd_taken     <= w_resolve && res_taken;
      r_mispredict    <= w_mispred;
      r_mispredict_pc <= w_mispred ? w_head_pc : '0;
      if (w_underflow) begin
        r_underflow <= 1'b1;
      end
    end
  end

  bp_sat_count #(.W(STAT_W)) u_resolved_cnt (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (w_resolve),
    .o_count (resolved_cnt)
  );

  bp_sat_count #(.W(STAT_W)) u_mispred_cnt (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (w_mispred),
    .o_count (mispred_cnt)
  );

  assign upd_valid     = r_upd_valid;
  assign upd_pc        = r_upd_pc;
  assign upd_taken     = r_upd_taken;
  assign mispredict    = r_mispredict;
  assign mispredict_pc = r_mispredict_pc;
  assign occupancy     = r_occ;
  assign underflow_err = r_underflow;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb/tb_branch_resolve_queue.sv - directed self-checking bench for branch_resolve_queue
module tb_branch_resolve_queue;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pred_valid = 1'b0;
  logic [9:0] pred_pc = '0;
  logic       pred_taken = 1'b0;
  logic       res_valid = 1'b0;
  logic       res_taken = 1'b0;

  logic        pred_ready, upd_valid, upd_taken, mispredict, underflow_err;
  logic [9:0]  upd_pc, mispredict_pc;
  logic [3:0]  occupancy;
  logic [15:0] resolved_cnt, mispred_cnt;

  logic        s_pred_ready, s_upd_valid, s_upd_taken, s_mispredict, s_underflow_err;
  logic [9:0]  s_upd_pc, s_mispredict_pc;
  logic [3:0]  s_occupancy;
  logic [3:0]  s_resolved_cnt, s_mispred_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  branch_resolve_queue dut (
    .clock(clock), .reset(reset),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .mispredict(mispredict), .mispredict_pc(mispredict_pc),
    .occupancy(occupancy), .resolved_cnt(resolved_cnt), .mispred_cnt(mispred_cnt),
    .underflow_err(underflow_err)
  );

  branch_resolve_queue #(.STAT_W(4)) dut_sat (
    .clock(clock), .reset(reset),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_ready(s_pred_ready),
    .res_valid(res_valid), .res_taken(res_taken),
    .upd_valid(s_upd_valid), .upd_pc(s_upd_pc), .upd_taken(s_upd_taken),
    .mispredict(s_mispredict), .mispredict_pc(s_mispredict_pc),
    .occupancy(s_occupancy), .resolved_cnt(s_resolved_cnt), .mispred_cnt(s_mispred_cnt),
    .underflow_err(s_underflow_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [9:0] ppc, input logic pt,
                       input logic rv, input logic rt);
    pred_valid = pv;
    pred_pc    = ppc;
    pred_taken = pt;
    res_valid  = rv;
    res_taken  = rt;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_upd_valid", 32'(upd_valid), 0);
    chk("rst_upd_pc", 32'(upd_pc), 0);
    chk("rst_mispredict", 32'(mispredict), 0);
    chk("rst_mispredict_pc", 32'(mispredict_pc), 0);
    chk("rst_occupancy", 32'(occupancy), 0);
    chk("rst_resolved_cnt", 32'(resolved_cnt), 0);
    chk("rst_mispred_cnt", 32'(mispred_cnt), 0);
    chk("rst_underflow", 32'(underflow_err), 0);
    chk("rst_pred_ready", 32'(pred_ready), 1);
    reset = 1'b0;
    tick();

    // In-order resolution, all correct
    drive(1, 10'd5, 1, 0, 0); tick();
    drive(1, 10'd6, 0, 0, 0); tick();
    drive(1, 10'd7, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0);
    chk("t1_occ3", 32'(occupancy), 3);
    drive(0, 0, 0, 1, 1); tick();
    chk("t1_upd_valid_a", 32'(upd_valid), 1);
    chk("t1_upd_pc_a", 32'(upd_pc), 5);
    chk("t1_upd_taken_a", 32'(upd_taken), 1);
    chk("t1_mispred_a", 32'(mispredict), 0);
    drive(0, 0, 0, 1, 0); tick();
    chk("t1_upd_pc_b", 32'(upd_pc), 6);
    chk("t1_upd_taken_b", 32'(upd_taken), 0);
    chk("t1_mispred_b", 32'(mispredict), 0);
    drive(0, 0, 0, 1, 1); tick();
    chk("t1_upd_pc_c", 32'(upd_pc), 7);
    chk("t1_mispred_c", 32'(mispredict), 0);
    drive(0, 0, 0, 0, 0); tick();
    chk("t1_upd_valid_idle", 32'(upd_valid), 0);
    chk("t1_resolved_cnt", 32'(resolved_cnt), 3);
    chk("t1_occ0", 32'(occupancy), 0);

    // Mispredict on head flushes younger entries; push in that cycle is dropped
    drive(1, 10'd1, 1, 0, 0); tick();
    drive(1, 10'd2, 1, 0, 0); tick();
    drive(1, 10'd3, 0, 0, 0); tick();
    drive(1, 10'd4, 1, 0, 0); tick();
    drive(1, 10'd9, 1, 1, 0);
    #1;
    chk("t2_ready_in_mispred", 32'(pred_ready), 0);
    tick();
    chk("t2_mispredict", 32'(mispredict), 1);
    chk("t2_mispredict_pc", 32'(mispredict_pc), 1);
    chk("t2_upd_valid", 32'(upd_valid), 1);
    chk("t2_upd_taken", 32'(upd_taken), 0);
    chk("t2_occ0", 32'(occupancy), 0);
    chk("t2_mispred_cnt", 32'(mispred_cnt), 1);
    chk("t2_ready_flush", 32'(pred_ready), 0);
    drive(1, 10'd9, 1, 1, 1); tick();
    drive(0, 0, 0, 0, 0);
    chk("t2_mispredict_one_cycle", 32'(mispredict), 0);
    chk("t2_flush_no_upd", 32'(upd_valid), 0);
    chk("t2_flush_no_err", 32'(underflow_err), 0);
    chk("t2_flush_occ0", 32'(occupancy), 0);
    chk("t2_ready_back", 32'(pred_ready), 1);
    chk("t2_resolved_cnt", 32'(resolved_cnt), 4);

    // Fill to DEPTH across a pointer wrap, push while full with a correct resolve
    for (int i = 10; i < 18; i++) begin
      drive(1, 10'(i), i[0], 0, 0); tick();
    end
    drive(1, 10'd99, 1, 0, 0);
    #1;
    chk("t3_ready_full", 32'(pred_ready), 0);
    tick();
    chk("t3_occ_full", 32'(occupancy), 8);
    drive(1, 10'd18, 0, 1, 0);
    #1;
    chk("t3_ready_full_pop", 32'(pred_ready), 1);
    tick();
    chk("t3_upd_pc_10", 32'(upd_pc), 10);
    chk("t3_no_mispred", 32'(mispredict), 0);
    chk("t3_occ_still_full", 32'(occupancy), 8);
    for (int i = 11; i < 19; i++) begin
      drive(0, 0, 0, 1, i[0]); tick();
      chk($sformatf("t3_drain_pc_%0d", i), 32'(upd_pc), 32'(i));
      chk($sformatf("t3_drain_mp_%0d", i), 32'(mispredict), 0);
    end
    drive(0, 0, 0, 0, 0); tick();
    chk("t3_occ_drained", 32'(occupancy), 0);
    chk("t3_resolved_cnt", 32'(resolved_cnt), 13);

    // Underflow is sticky; async reset clears everything mid-cycle
    drive(1, 10'd20, 1, 1, 1); tick();
    chk("t4_no_upd_on_empty", 32'(upd_valid), 0);
    chk("t4_underflow", 32'(underflow_err), 1);
    chk("t4_push_kept", 32'(occupancy), 1);
    drive(0, 0, 0, 0, 0); tick();
    chk("t4_underflow_sticky", 32'(underflow_err), 1);
    for (int i = 21; i < 25; i++) begin
      drive(1, 10'(i), 1, 0, 0); tick();
    end
    drive(0, 0, 0, 1, 1);
    #1;
    chk("t4_occ5", 32'(occupancy), 5);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("t4_async_occ", 32'(occupancy), 0);
    chk("t4_async_underflow", 32'(underflow_err), 0);
    chk("t4_async_upd_valid", 32'(upd_valid), 0);
    chk("t4_async_upd_pc", 32'(upd_pc), 0);
    chk("t4_async_resolved", 32'(resolved_cnt), 0);
    chk("t4_async_ready", 32'(pred_ready), 1);
    drive(0, 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b0;
    tick();

    // 20 correct resolves: 4-bit counter saturates at 15
    for (int i = 0; i < 20; i++) begin
      drive(1, 10'(30 + i), 1, (i > 0), 1); tick();
    end
    drive(0, 0, 0, 1, 1); tick();
    drive(0, 0, 0, 0, 0); tick();
    chk("t5_sat_resolved", 32'(s_resolved_cnt), 15);
    chk("t5_wide_resolved", 32'(resolved_cnt), 20);
    chk("t5_sat_mispred", 32'(s_mispred_cnt), 0);
    chk("t5_occ0", 32'(occupancy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

Resolution-side companion to the 2-bit saturating prediction counters. Holds every issued prediction in order until the branch resolves, compares the predicted direction with the actual outcome, and drives the registered training stream (`upd_taken` is the actual-outcome input of the counter tables). On a misprediction it flushes all younger in-flight predictions and reports the redirect PC. It sits between the predictor front end (writer) and the execute-stage branch unit (resolver).

## Interface
- `DEPTH`, 8: number of in-flight predictions; power of two, 2..64.
- `PC_W`, 10: width of the stored branch index/PC.
- `STAT_W`, 16: width of the statistics counters.

- `clock`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `pred_valid`  in  1  a new prediction is offered.
- `pred_pc`  in  PC_W  index of the predicted branch.
- `pred_taken`  in  1  predicted direction.
- `pred_ready`  out  1  push accepted this cycle: not full and state ACTIVE.
- `res_valid`  in  1  the oldest in-flight branch resolves.
- `res_taken`  in  1  actual direction.
- `upd_valid`  out  1  training update valid, registered.
- `upd_pc`  out  PC_W  index to train.
- `upd_taken`  out  1  actual outcome.
- `mispredict`  out  1  registered one-cycle pulse.
- `mispredict_pc`  out  PC_W  PC of the mispredicted branch.
- `occupancy`  out  $clog2(DEPTH)+1  current entry count.
- `resolved_cnt`  out  STAT_W  saturating count of resolutions.
- `mispred_cnt`  out  STAT_W  saturating count of mispredictions.
- `underflow_err`  out  1  sticky: resolution arrived while empty.

## Operation
- Circular FIFO of `{pc, taken}` entries. Write and read pointers are $clog2(DEPTH)+1 bits; wrap is natural modulo. Full when the pointer MSBs differ and the low bits are equal. Empty when the pointers are equal.
- Push occurs when `pred_valid && pred_ready`: the entry is written at `wptr` and `wptr` increments.
- Resolve occurs when `res_valid` and the queue is not empty:
  - The head entry is popped.
  - `upd_valid`=1, `upd_pc`=head.pc, `upd_taken`=`res_taken`.
  - `resolved_cnt` increments.
  - If head.taken != `res_taken`: `mispredict`=1, `mispredict_pc`=head.pc, and `mispred_cnt` increments.
- Resolve while empty: no pop and no update. `underflow_err` is set and stays set until reset.
- State machine `{ACTIVE, FLUSH}`:
  - ACTIVE → FLUSH on a mispredicting resolve. In that same edge all remaining entries are discarded: `rptr` is set to `wptr`, and any push offered that cycle is dropped. `pred_ready` is 0 in that cycle because the mispredict is decoded combinationally from the inputs.
  - FLUSH → ACTIVE unconditionally after one cycle. In FLUSH, `pred_ready`=0 and any `res_valid` is ignored (no error).
- Simultaneous push and correct resolve: both take effect and `occupancy` is unchanged. Push is allowed when full only if a correct resolve pops in the same cycle (`pred_ready` = !full || (res_valid && correct)).
- Statistics counters saturate at all-ones and never wrap.

## Timing
- Reset values:
  - pointers 0, state ACTIVE
  - `upd_valid`, `upd_pc`, `upd_taken` = 0
  - `mispredict`, `mispredict_pc` = 0
  - `occupancy`, `resolved_cnt`, `mispred_cnt` = 0
  - `underflow_err` = 0
  - `pred_ready` = 1
- Reset mid-operation drops all entries immediately (asynchronous).
- `res_valid` at edge N produces `upd_*` and `mispredict` valid in cycle N+1, each for exactly one cycle.
- A pushed entry can be resolved in the cycle after its push. Same-cycle push-and-resolve of one entry is not supported: an empty queue with `res_valid` sets the error even if a push is present.
- `occupancy` is registered and reflects all pushes and pops of the previous edge.

## Structure
- Shared package `bp_pkg`:
  - `bp_entry_t` (packed struct `{pc, taken}`, parameterized via PC_W constant `BP_PC_W`)
  - `rq_state_e` `{ACTIVE, FLUSH}`
  - default `BP_RQ_DEPTH`
- One sub-module, `bp_sat_count`: parameterized saturating up-counter with asynchronous reset. It is instantiated twice, for the statistics counters.

## Test plan
- Reset, push 3 entries (pc 5/T, 6/N, 7/T), resolve T, N, T → three `upd_valid` pulses with pcs 5, 6, 7; `mispredict` never asserted; `resolved_cnt`=3, `occupancy`=0.
- Push 4 entries, resolve the head (pc 1, predicted T) with actual N → next cycle `mispredict`=1, `mispredict_pc`=1, `upd_taken`=0; `occupancy`=0; `pred_ready`=0 for one cycle, then 1; `mispred_cnt`=1.
- Fill DEPTH=8 entries → `pred_ready`=0. Then push with a correct resolve in the same cycle → accepted, `occupancy` stays 8. Drain all 8 across a pointer wrap → pcs come out in order.
- `res_valid` on an empty queue → no `upd_valid`, `underflow_err`=1 and sticky. Assert `reset` mid-stream with 5 entries → all outputs return to reset values asynchronously.
- Push in the mispredict cycle and `res_valid` during FLUSH → both ignored; `occupancy`=0 afterward; no error.
- Force STAT_W=4 and run 20 correct resolves → `resolved_cnt` saturates at 15.
